// File: rtl/conv_row_addr_seq.sv
// Row-window address sequencer for the 3x3 convolution datapath: issues top/mid/bottom
// row addresses, rotating line-buffer indices and padding-aware valids, one beat per cycle.
module conv_row_addr_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] cols_words,
  input  logic [15:0] rows,
  output logic [15:0] row1_buf_adr,
  output logic [15:0] row2_buf_adr,
  output logic [15:0] row3_buf_adr,
  output logic [1:0]  row1_buf_idx,
  output logic [1:0]  row2_buf_idx,
  output logic [1:0]  row3_buf_idx,
  output logic [15:0] row1_slab_adr,
  output logic [15:0] row2_slab_adr,
  output logic [15:0] row3_slab_adr,
  output logic [1:0]  row1_slab_idx,
  output logic [1:0]  row2_slab_idx,
  output logic [1:0]  row3_slab_idx,
  output logic        valid_row1_adr,
  output logic        valid_row2_adr,
  output logic        valid_row3_adr,
  output logic        col_first,
  output logic        col_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] rows_q, cols_q, r_q, c_q;
  logic [1:0]  cur1, cur2, cur3;
  logic        last_col, last_beat, sizes_ok;

  assign sizes_ok  = (cols_words != '0) && (rows != '0);
  assign last_col  = (c_q == cols_q - 16'd1);
  assign last_beat = last_col && (r_q == rows_q - 16'd1);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign row1_slab_idx = row1_buf_idx;
  assign row2_slab_idx = row2_buf_idx;
  assign row3_slab_idx = row3_buf_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = sizes_ok ? RUN : DONE;
      RUN:  if (en && last_beat) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cur* track the indices of the row being walked; the output idx registers
  // copy them per beat so a rotation on the last column shows from the next beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q         <= '0;
      cols_q         <= '0;
      r_q            <= '0;
      c_q            <= '0;
      cur1           <= 2'd3;
      cur2           <= 2'd1;
      cur3           <= 2'd2;
      row1_buf_adr   <= '1;
      row2_buf_adr   <= '1;
      row3_buf_adr   <= '1;
      row1_slab_adr  <= '1;
      row2_slab_adr  <= '1;
      row3_slab_adr  <= '1;
      row1_buf_idx   <= 2'd3;
      row2_buf_idx   <= 2'd1;
      row3_buf_idx   <= 2'd2;
      valid_row1_adr <= 1'b0;
      valid_row2_adr <= 1'b0;
      valid_row3_adr <= 1'b0;
      col_first      <= 1'b0;
      col_last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && sizes_ok) begin
            rows_q <= rows;
            cols_q <= cols_words;
            r_q    <= '0;
            c_q    <= '0;
            cur1   <= 2'd3;
            cur2   <= 2'd1;
            cur3   <= 2'd2;
          end
        end
        RUN: begin
          if (en) begin
            row1_buf_adr   <= c_q;
            row2_buf_adr   <= c_q;
            row3_buf_adr   <= c_q;
            row1_slab_adr  <= c_q - 16'd1;
            row2_slab_adr  <= c_q - 16'd1;
            row3_slab_adr  <= c_q - 16'd1;
            row1_buf_idx   <= cur1;
            row2_buf_idx   <= cur2;
            row3_buf_idx   <= cur3;
            valid_row1_adr <= (r_q != '0);
            valid_row2_adr <= 1'b1;
            valid_row3_adr <= (r_q != rows_q - 16'd1);
            col_first      <= (c_q == '0);
            col_last       <= last_col;
            if (last_col) begin
              c_q  <= '0;
              r_q  <= r_q + 16'd1;
              cur1 <= cur2;
              cur2 <= cur3;
              cur3 <= cur1;
            end else begin
              c_q <= c_q + 16'd1;
            end
          end
        end
        DONE: begin
          valid_row1_adr <= 1'b0;
          valid_row2_adr <= 1'b0;
          valid_row3_adr <= 1'b0;
          row1_buf_idx   <= 2'd3;
          row2_buf_idx   <= 2'd1;
          row3_buf_idx   <= 2'd2;
          cur1           <= 2'd3;
          cur2           <= 2'd1;
          cur3           <= 2'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_addr_seq.sv
// Self-checking bench for conv_row_addr_seq: expected beats are queued at frame start
// and popped as the sequencer issues them.
module tb_conv_row_addr_seq;

  logic        clk = 1'b0;
  logic        reset, en, start;
  logic [15:0] cols_words, rows;
  logic [15:0] row1_buf_adr, row2_buf_adr, row3_buf_adr;
  logic [1:0]  row1_buf_idx, row2_buf_idx, row3_buf_idx;
  logic [15:0] row1_slab_adr, row2_slab_adr, row3_slab_adr;
  logic [1:0]  row1_slab_idx, row2_slab_idx, row3_slab_idx;
  logic        valid_row1_adr, valid_row2_adr, valid_row3_adr;
  logic        col_first, col_last, busy, done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] adr;
    logic [15:0] slab;
    logic [1:0]  i1, i2, i3;
    logic        v1, v3, cf, cl;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  conv_row_addr_seq dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .cols_words(cols_words), .rows(rows),
    .row1_buf_adr(row1_buf_adr), .row2_buf_adr(row2_buf_adr), .row3_buf_adr(row3_buf_adr),
    .row1_buf_idx(row1_buf_idx), .row2_buf_idx(row2_buf_idx), .row3_buf_idx(row3_buf_idx),
    .row1_slab_adr(row1_slab_adr), .row2_slab_adr(row2_slab_adr), .row3_slab_adr(row3_slab_adr),
    .row1_slab_idx(row1_slab_idx), .row2_slab_idx(row2_slab_idx), .row3_slab_idx(row3_slab_idx),
    .valid_row1_adr(valid_row1_adr), .valid_row2_adr(valid_row2_adr), .valid_row3_adr(valid_row3_adr),
    .col_first(col_first), .col_last(col_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input int nr, input int nc);
    beat_t b;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        b.adr  = 16'(c);
        b.slab = (c == 0) ? 16'hFFFF : 16'(c - 1);
        b.i1   = 2'(((r + 2) % 3) + 1);
        b.i2   = 2'((r % 3) + 1);
        b.i3   = 2'(((r + 1) % 3) + 1);
        b.v1   = (r != 0);
        b.v3   = (r != nr - 1);
        b.cf   = (c == 0);
        b.cl   = (c == nc - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t b);
    chk({tag, ".adr"}, {48'd0, row1_buf_adr, row2_buf_adr, row3_buf_adr}, {48'd0, b.adr, b.adr, b.adr});
    chk({tag, ".slab"}, {48'd0, row1_slab_adr, row2_slab_adr, row3_slab_adr}, {48'd0, b.slab, b.slab, b.slab});
    chk({tag, ".idx"}, {84'd0, row1_buf_idx, row2_buf_idx, row3_buf_idx, row1_slab_idx, row2_slab_idx, row3_slab_idx},
        {84'd0, b.i1, b.i2, b.i3, b.i1, b.i2, b.i3});
    chk({tag, ".valid"}, {93'd0, valid_row1_adr, valid_row2_adr, valid_row3_adr}, {93'd0, b.v1, 1'b1, b.v3});
    chk({tag, ".col"}, {94'd0, col_first, col_last}, {94'd0, b.cf, b.cl});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".adr"}, {row1_buf_adr, row2_buf_adr, row3_buf_adr, row1_slab_adr, row2_slab_adr, row3_slab_adr}, '1);
    chk({tag, ".idx"}, {84'd0, row1_buf_idx, row2_buf_idx, row3_buf_idx, row1_slab_idx, row2_slab_idx, row3_slab_idx},
        {84'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2});
    chk({tag, ".flags"}, {89'd0, valid_row1_adr, valid_row2_adr, valid_row3_adr, col_first, col_last, busy, done}, '0);
  endtask

  // stall_at/start_at/abort_at: beat count at which to stall, pulse start, or reset (-1 = never).
  task automatic run_frame(input string tag, input int nr, input int nc, input int stall_at,
                           input int stall_len, input int start_at, input int abort_at);
    beat_t b, last;
    int seen = 0;
    int stalled = 0;
    int cyc = 0;
    push_frame(nr, nc);
    rows = 16'(nr); cols_words = 16'(nc);
    start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_start"}, {95'd0, busy}, {95'd0, 1'b1});
    while (exp_q.size() > 0 && cyc < 1000) begin
      cyc++;
      if (seen == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_vals({tag, ".abort"});
        exp_q.delete();
        @(posedge clk); #1;
        chk({tag, ".no_done"}, {94'd0, busy, done}, '0);
        return;
      end
      en    = !(seen == stall_at && stalled < stall_len);
      start = (seen == start_at);
      @(posedge clk); #1;
      if (en) begin
        b = exp_q.pop_front();
        chk_beat($sformatf("%s.beat%0d", tag, seen), b);
        last = b;
        seen++;
      end else begin
        chk_beat($sformatf("%s.stall%0d", tag, stalled), last);
        stalled++;
      end
      chk($sformatf("%s.done%0d", tag, cyc), {95'd0, done}, {95'd0, exp_q.size() == 0});
    end
    chk({tag, ".timeout"}, 96'(exp_q.size()), '0);
    start = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".end"}, {89'd0, busy, done, valid_row1_adr, valid_row2_adr, valid_row3_adr,
                        row1_buf_idx, row2_buf_idx}, {89'd0, 5'b00000, 2'd3, 2'd1});
    chk({tag, ".end_idx3"}, {94'd0, row3_buf_idx}, {94'd0, 2'd2});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; start = 1'b0; cols_words = '0; rows = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame("f2x3", 3, 2, -1, 0, -1, -1);
    run_frame("stall", 3, 2, 3, 3, -1, -1);
    run_frame("rows1", 1, 3, -1, 0, -1, -1);

    // zero-size frame: straight to DONE, no valid ever asserted
    cols_words = 16'd0; rows = 16'd3; start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cols0.done", {93'd0, busy, done, valid_row1_adr | valid_row2_adr | valid_row3_adr}, {93'd0, 3'b110});
    @(posedge clk); #1;
    chk("cols0.idle", {93'd0, busy, done, valid_row1_adr | valid_row2_adr | valid_row3_adr}, '0);

    run_frame("startrun", 3, 2, -1, 0, 2, -1);
    run_frame("abort", 4, 4, -1, 0, -1, 5);
    run_frame("full4x4", 4, 4, -1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
